// File: rtl/pe_seq_pkg.sv
// pe_seq_pkg
//   Shared types and sizing helpers for the PE feed sequencer.
//   - seq_state_t : sequencer state (IDLE, FEED, DRAIN, DONE)
//   - cycle_len   : number of FEED cycles for an N-wide skewed tile (2N-1)
//   - cnt_width   : width of the shared FEED/DRAIN cycle counter
package pe_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  function automatic int cycle_len(input int n);
    return 2 * n - 1;
  endfunction

  // One counter serves both FEED and DRAIN, so it must hold the larger
  // of the two terminal counts.
  function automatic int cnt_width(input int n, input int drain);
    int longest;
    longest = (cycle_len(n) > drain) ? cycle_len(n) : drain;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/pe_skew_lane.sv
// pe_skew_lane
//   Element select for one skewed data lane. Lane LANE carries column LANE
//   of the tile, delayed by LANE cycles: on FEED count cnt it presents
//   element (cnt-LANE, LANE) while that row index lies inside the tile.
// Ports:
//   cnt  in   FEED cycle counter
//   idx  out  row-major tile index N*(cnt-LANE)+LANE (0 when outside window)
//   vld  out  1 when LANE <= cnt < LANE+N
module pe_skew_lane #(
  parameter int ARRAY_SIZE = 8,
  parameter int LANE       = 0,
  parameter int CNT_W      = 4,
  parameter int IDX_W      = $clog2(ARRAY_SIZE * ARRAY_SIZE)
) (
  input  logic [CNT_W-1:0] cnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  int row;

  always_comb begin
    row = int'(cnt) - LANE;
    vld = (row >= 0) && (row < ARRAY_SIZE);
    idx = '0;
    if (vld) begin
      idx = IDX_W'(row * ARRAY_SIZE + LANE);
    end
  end

endmodule

// File: rtl/pe_feed_sequencer.sv
// pe_feed_sequencer
//   Accepts an N x N signed activation tile, streams it into the systolic
//   array with diagonal skew (lane c delayed by c cycles), drains the array
//   for DRAIN_CYCLES and captures the array's result row.
//   Optional feature macro: PE_SEQ_STALL_EN adds a stall input that freezes
//   FEED/DRAIN progress and blanks the lanes while asserted.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        tile request, honoured only in IDLE
//   abort        cancel an in-flight tile (FEED/DRAIN)
//   stall        (PE_SEQ_STALL_EN only) freeze FEED/DRAIN
//   tile_in      row-major tile, element (r,c) at N*r+c
//   busy         high while a tile is in flight
//   compute      array enable
//   datas_out    skewed lane data to the array
//   results_in   array result row
//   results_out  captured result row, held until next capture
//   done         one-cycle pulse when results_out updates
module pe_feed_sequencer
  import pe_seq_pkg::*;
#(
  parameter int ARRAY_SIZE             = 8,
  parameter int COMPUTE_DATA_WIDTH     = 4,
  parameter int ACCUMULATOR_DATA_WIDTH = 16,
  parameter int DRAIN_CYCLES           = ARRAY_SIZE
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     abort,
`ifdef PE_SEQ_STALL_EN
  input  logic                                     stall,
`endif
  input  logic signed [COMPUTE_DATA_WIDTH-1:0]     tile_in     [ARRAY_SIZE*ARRAY_SIZE],
  output logic                                     busy,
  output logic                                     compute,
  output logic signed [COMPUTE_DATA_WIDTH-1:0]     datas_out   [ARRAY_SIZE],
  input  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] results_in  [ARRAY_SIZE],
  output logic signed [ACCUMULATOR_DATA_WIDTH-1:0] results_out [ARRAY_SIZE],
  output logic                                     done
);

  localparam int CNT_W     = cnt_width(ARRAY_SIZE, DRAIN_CYCLES);
  localparam int IDX_W     = $clog2(ARRAY_SIZE * ARRAY_SIZE);
  localparam int FEED_LAST = cycle_len(ARRAY_SIZE) - 1;

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load;
  logic             feed_en;
  logic             capture;
  logic             busy_nxt, compute_nxt, done_nxt;
  logic             stall_w;

  logic signed [COMPUTE_DATA_WIDTH-1:0] tile_p0  [ARRAY_SIZE*ARRAY_SIZE];
  logic        [IDX_W-1:0]              lane_idx [ARRAY_SIZE];
  logic                                 lane_vld [ARRAY_SIZE];
  logic signed [COMPUTE_DATA_WIDTH-1:0] lane_nxt [ARRAY_SIZE];

`ifdef PE_SEQ_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // State and cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    load        = 1'b0;
    feed_en     = 1'b0;
    capture     = 1'b0;
    compute_nxt = 1'b0;
    done_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        // start beats a simultaneous abort; abort has no meaning here.
        if (start) begin
          load      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = FEED;
        end
      end
      FEED: begin
        if (abort) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (!stall_w) begin
          feed_en     = 1'b1;
          compute_nxt = 1'b1;
          if (cnt == CNT_W'(FEED_LAST)) begin
            cnt_nxt   = '0;
            state_nxt = DRAIN;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (!stall_w) begin
          compute_nxt = 1'b1;
          if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        capture   = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy is registered from the next state so it rises on the accept edge.
  assign busy_nxt = (state_nxt != IDLE);

  // Tile capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARRAY_SIZE * ARRAY_SIZE; i++) tile_p0[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < ARRAY_SIZE * ARRAY_SIZE; i++) tile_p0[i] <= tile_in[i];
    end
  end

  for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_lane
    pe_skew_lane #(
      .ARRAY_SIZE (ARRAY_SIZE),
      .LANE       (c),
      .CNT_W      (CNT_W),
      .IDX_W      (IDX_W)
    ) u_lane (
      .cnt (cnt),
      .idx (lane_idx[c]),
      .vld (lane_vld[c])
    );
    assign lane_nxt[c] = (feed_en && lane_vld[c]) ? tile_p0[lane_idx[c]] : '0;
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      compute <= 1'b0;
      done    <= 1'b0;
      for (int c = 0; c < ARRAY_SIZE; c++) begin
        datas_out[c]   <= '0;
        results_out[c] <= '0;
      end
    end else begin
      busy    <= busy_nxt;
      compute <= compute_nxt;
      done    <= done_nxt;
      for (int c = 0; c < ARRAY_SIZE; c++) begin
        datas_out[c] <= lane_nxt[c];
        if (capture) results_out[c] <= results_in[c];
      end
    end
  end

endmodule

// File: tb/tb_pe_feed_sequencer.sv
// tb_pe_feed_sequencer
//   Scoreboard bench for pe_feed_sequencer at N=4, DRAIN_CYCLES=4.
//   Stimulus pushes the expected lane vectors and result captures derived
//   from the tile/skew rules; a negedge monitor pops and compares them.
//   Stall scenario is included when PE_SEQ_STALL_EN is defined.
module tb_pe_feed_sequencer;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int CW = 4;
  localparam int AW = 16;

  typedef struct {
    logic [N*AW-1:0] res;
    int              cyc;
  } done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
`ifdef PE_SEQ_STALL_EN
  logic stall = 1'b0;
`endif
  logic signed [CW-1:0] tile_in     [N*N];
  logic                 busy, compute, done;
  logic signed [CW-1:0] datas_out   [N];
  logic signed [AW-1:0] results_in  [N];
  logic signed [AW-1:0] results_out [N];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int dones_exp = 0;
  bit log_en = 1'b0;
  logic [N*CW-1:0]      lane_q [$];
  done_t                done_q [$];
  logic signed [CW-1:0] lane2_log [$];
  logic [N*AW-1:0]      last_res = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe_feed_sequencer #(
    .ARRAY_SIZE             (N),
    .COMPUTE_DATA_WIDTH     (CW),
    .ACCUMULATOR_DATA_WIDTH (AW),
    .DRAIN_CYCLES           (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
`ifdef PE_SEQ_STALL_EN
    .stall       (stall),
`endif
    .tile_in     (tile_in),
    .busy        (busy),
    .compute     (compute),
    .datas_out   (datas_out),
    .results_in  (results_in),
    .results_out (results_out),
    .done        (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*CW-1:0] pack_lanes();
    logic [N*CW-1:0] v;
    for (int c = 0; c < N; c++) v[c*CW +: CW] = datas_out[c];
    return v;
  endfunction

  function automatic logic [N*AW-1:0] pack_res(input logic signed [AW-1:0] r [N]);
    logic [N*AW-1:0] v;
    for (int c = 0; c < N; c++) v[c*AW +: AW] = r[c];
    return v;
  endfunction

  function automatic logic [N*AW-1:0] pack_res_out();
    logic [N*AW-1:0] v;
    for (int c = 0; c < N; c++) v[c*AW +: AW] = results_out[c];
    return v;
  endfunction

  // Reference: on FEED step k, lane c carries tile row k-c, column c.
  function automatic logic [N*CW-1:0] feed_vec(input logic signed [CW-1:0] t [N*N], input int k);
    logic [N*CW-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) begin
      if (k - c >= 0 && k - c < N) v[c*CW +: CW] = t[(k - c) * N + c];
    end
    return v;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    done_t d;
    if (!rst) begin
      if (compute) begin
        chk("lane_expected", 64'(lane_q.size() != 0), 64'(1));
        if (lane_q.size() != 0) chk("lanes", 64'(pack_lanes()), 64'(lane_q.pop_front()));
        if (log_en) lane2_log.push_back(datas_out[2]);
      end else begin
        chk("lanes_idle_zero", 64'(pack_lanes()), 64'(0));
      end
      if (done) begin
        done_cnt++;
        chk("done_expected", 64'(done_q.size() != 0), 64'(1));
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          chk("done_results", pack_res_out(), d.res);
          chk("done_cycle", 64'(cyc), 64'(d.cyc));
        end
      end
    end
  end

  task automatic run_tile(input logic signed [CW-1:0] t [N*N],
                          input logic signed [AW-1:0] r [N],
                          input int stall_len, input bit reassert);
    done_t d;
    int prev;
    for (int k = 0; k < 2*N-1; k++) lane_q.push_back(feed_vec(t, k));
    for (int k = 0; k < D; k++) lane_q.push_back('0);
    tile_in    = t;
    results_in = r;
    start      = 1'b1;
    d.res = pack_res(r);
    d.cyc = cyc + 1 + 2*N + D + stall_len;
    done_q.push_back(d);
    dones_exp++;
    last_res = d.res;
    prev = done_cnt;
    tick();
    start = 1'b0;
    tick();
    tick();
    if (reassert) begin
      start = 1'b1;
      for (int i = 0; i < N*N; i++) tile_in[i] = CW'($urandom);
      tick();
      start = 1'b0;
    end
`ifdef PE_SEQ_STALL_EN
    if (stall_len > 0) begin
      stall = 1'b1;
      repeat (stall_len) tick();
      stall = 1'b0;
    end
`endif
    for (int i = 0; i < 80 && done_cnt == prev; i++) tick();
    chk("done_seen", 64'(done_cnt - prev), 64'(1));
  endtask

  task automatic rand_tile(output logic signed [CW-1:0] t [N*N], output logic signed [AW-1:0] r [N]);
    for (int i = 0; i < N*N; i++) t[i] = CW'($urandom);
    for (int c = 0; c < N; c++) r[c] = AW'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [CW-1:0] t [N*N];
    logic signed [AW-1:0] r [N];
    int exp2 [7] = '{0, 0, -6, -2, 2, 6, 0};

    for (int i = 0; i < N*N; i++) tile_in[i] = '0;
    for (int c = 0; c < N; c++) results_in[c] = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_compute", 64'(compute), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_lanes", 64'(pack_lanes()), 64'(0));
    chk("rst_results", pack_res_out(), '0);
    rst = 1'b0;
    repeat (2) tick();

    // Directed tile (r,c) = 4r+c-8 with fixed result row
    for (int rr = 0; rr < N; rr++)
      for (int cc = 0; cc < N; cc++) t[rr*N+cc] = CW'(rr*4 + cc - 8);
    r[0] = AW'(100); r[1] = AW'(-200); r[2] = AW'(300); r[3] = AW'(-400);
    lane2_log.delete();
    log_en = 1'b1;
    run_tile(t, r, 0, 1'b0);
    log_en = 1'b0;
    chk("lane2_len", 64'(lane2_log.size()), 64'(2*N-1+D));
    for (int i = 0; i < 7 && i < lane2_log.size(); i++)
      chk("lane2_seq", 64'(int'(lane2_log[i])), 64'(exp2[i]));
    for (int c = 0; c < N; c++) results_in[c] = AW'($urandom);
    repeat (3) tick();
    chk("results_hold", pack_res_out(), last_res);

    // start re-asserted during FEED with a different tile on the bus
    rand_tile(t, r);
    run_tile(t, r, 0, 1'b1);
    repeat (6) tick();

    // Abort in the third FEED cycle
    rand_tile(t, r);
    lane_q.push_back(feed_vec(t, 0));
    lane_q.push_back(feed_vec(t, 1));
    tile_in = t;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_compute", 64'(compute), 64'(0));
    chk("abort_lanes", 64'(pack_lanes()), 64'(0));
    chk("abort_results", pack_res_out(), last_res);
    repeat (20) tick();
    rand_tile(t, r);
    run_tile(t, r, 0, 1'b0);

    // Random tiles back to back
    for (int n = 0; n < 5; n++) begin
      rand_tile(t, r);
      run_tile(t, r, 0, ($urandom_range(3) == 0));
    end

    // Asynchronous reset in the middle of DRAIN
    rand_tile(t, r);
    for (int k = 0; k < 2*N-1; k++) lane_q.push_back(feed_vec(t, k));
    lane_q.push_back('0);
    tile_in = t;
    results_in = r;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_compute", 64'(compute), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_lanes", 64'(pack_lanes()), 64'(0));
    chk("midrst_results", pack_res_out(), '0);
    #2;
    rst = 1'b0;
    last_res = '0;
    repeat (5) tick();
    chk("postrst_busy", 64'(busy), 64'(0));
    chk("postrst_compute", 64'(compute), 64'(0));
    rand_tile(t, r);
    run_tile(t, r, 0, 1'b0);

`ifdef PE_SEQ_STALL_EN
    rand_tile(t, r);
    run_tile(t, r, 3, 1'b0);
`endif

    repeat (5) tick();
    chk("lane_q_empty", 64'(lane_q.size()), 64'(0));
    chk("done_q_empty", 64'(done_q.size()), 64'(0));
    chk("done_count", 64'(done_cnt), 64'(dones_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_feed_sequencer.md
# pe_feed_sequencer

Parametrised tile sequencer for the systolic PE array. It accepts a full ARRAY_SIZE×ARRAY_SIZE activation tile with a start/busy/done handshake and feeds it into the array's per-row data lanes with diagonal skew. It then drains the array for a fixed latency and captures the array's result row. It replaces the fixed 8-lane skew logic with generated lanes, a real cycle counter and an explicit state machine.

## Interface
Parameters:
- ARRAY_SIZE, 8, array dimension N; ≥2
- COMPUTE_DATA_WIDTH, 4, signed activation width
- ACCUMULATOR_DATA_WIDTH, 16, signed result width
- DRAIN_CYCLES, ARRAY_SIZE, cycles between last feed and result capture; ≥1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request a tile; sampled only in IDLE
- abort  in  1  synchronous cancel of an in-flight tile
- tile_in  in  [N*N] × COMPUTE_DATA_WIDTH signed  row-major tile, element (r,c) at index N*r+c; captured when start is accepted
- busy  out  1  high in FEED, DRAIN, DONE
- compute  out  1  array enable; high in FEED and DRAIN
- datas_out  out  [N] × COMPUTE_DATA_WIDTH signed  skewed lanes to the array
- results_in  in  [N] × ACCUMULATOR_DATA_WIDTH signed  array result row
- results_out  out  [N] × ACCUMULATOR_DATA_WIDTH signed  captured results, held until the next capture
- done  out  1  one-cycle pulse when results_out is updated

## Operation
- States: IDLE → FEED → DRAIN → DONE → IDLE.
- IDLE: if start=1, register tile_in, clear cnt, go to FEED. Otherwise hold.
- FEED: cnt runs 0..2N-2. Lane c presents tile[N*(cnt-c)+c] when c ≤ cnt < c+N, and 0 otherwise. At cnt=2N-2, clear cnt and go to DRAIN.
- DRAIN: all lanes present 0. cnt runs 0..DRAIN_CYCLES-1, then the state goes to DONE.
- DONE: results_out ← results_in at the entry edge. done=1 for this single cycle. Next state is IDLE.
- start outside IDLE is ignored; it is not queued.
- abort=1 in FEED or DRAIN: next state is IDLE, datas_out is zeroed, compute drops, and there is no done pulse. results_out is unchanged. abort in IDLE or DONE has no effect.
- abort and start together in IDLE: start wins.
- Counter width is $clog2(max(2N-1, DRAIN_CYCLES)+1). No wrap occurs within a state.

## Timing
- Reset values: state=IDLE, cnt=0, busy=0, compute=0, done=0, datas_out all 0, results_out all 0, tile register all 0.
- All outputs are registered.
- With start accepted at edge E0:
  - datas_out[0]=tile[0] and compute=1 after edge E1.
  - The last non-zero lane value, datas_out[N-1]=tile[N*N-1], appears after edge E(2N-1).
  - DRAIN occupies the cycles after edges E2N..E(2N+DRAIN_CYCLES-1).
  - done=1 after edge E(2N+DRAIN_CYCLES).
  - The earliest next start is accepted at the edge following the done cycle.
- Reset mid-operation forces the reset values immediately, regardless of the clock.

## Configuration
- PE_SEQ_STALL_EN defined: adds input stall (1 bit).
  - While stall=1 in FEED or DRAIN: cnt and state freeze, datas_out is driven to 0, compute=0.
  - Feeding resumes from the frozen cnt on the first cycle with stall=0.
  - abort overrides stall.
- PE_SEQ_STALL_EN undefined: the stall port is absent and the sequencer is never frozen.

## Structure
- Package pe_seq_pkg holds:
  - the state typedef (IDLE, FEED, DRAIN, DONE);
  - the cycle-length function 2*N-1;
  - the counter-width function.
- Sub-module pe_skew_lane computes one lane's element select and valid window from cnt and its lane index parameter. It is instantiated N times by generate.

## Test plan
- N=4, tile value (r,c) = r*4+c-8; start pulse:
  - lane 2 shows 0,0,-6,-2,2,6,0 over the 7 FEED cycles;
  - done appears 12 cycles after the start edge.
- results_in held at {100,-200,300,-400} during DRAIN → results_out equals those values at done. results_out then holds them while results_in changes afterwards.
- start re-asserted during FEED → ignored: exactly one done pulse, and the lanes follow the first tile.
- abort in the 3rd FEED cycle → IDLE next cycle, datas_out=0, compute=0, no done. A new start afterwards runs a full tile.
- rst asserted mid-DRAIN, between clock edges → all outputs take their reset values immediately. After release the block is idle until start.
- PE_SEQ_STALL_EN defined: stall for 3 cycles at FEED cnt=2 → lanes zero for those cycles, then resume at cnt=2. done is delayed by exactly 3 cycles.
